// File: rtl/semafor_pkg.sv
// semafor_pkg: shared types and defaults for the crossing controller and its pedestrian request unit.
package semafor_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WALK, COOL} ped_state_e;
  typedef enum logic [1:0] {RED, YELLOW, GREEN} lamp_e;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_BLINK_HALF = 2;
endpackage

// File: rtl/semafor_ped_request_if.sv
// semafor_ped_request_if: button and lamp inputs plus request/indicator outputs of the pedestrian unit.
interface semafor_ped_request_if;
  logic btn;
  logic R_P;
  logic G_P;
  logic sw;
  logic wait_lamp;
  logic fault;
  modport master (output btn, R_P, G_P, input sw, wait_lamp, fault);
  modport slave (input btn, R_P, G_P, output sw, wait_lamp, fault);
endinterface

// File: rtl/semafor_debounce.sv
// semafor_debounce: two-flop synchronizer followed by a stable-level debounce counter.
module semafor_debounce
  import semafor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_db_o
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic [W-1:0] cnt_q;
  logic db_q;
  assign btn_db_o = db_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      db_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == db_q) cnt_q <= '0;
      else if (cnt_q == W'(DEBOUNCE_CYCLES)) begin
        db_q <= sync_q[1];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/semafor_ped_request.sv
// semafor_ped_request: pedestrian request latch with cooldown and lamp-pair fault monitor.
// Define SEMAFOR_PED_BLINK_EN to make the wait lamp blink while a request is outstanding.
module semafor_ped_request
  import semafor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input logic clk,
  input logic rst_n,
  semafor_ped_request_if.slave bus
);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  ped_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic btn_db, db_q, press, eq, eq_q, fault_q, fault_d, pending_q, sw_q, wait_q, blink_on;
  semafor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .btn_i(bus.btn),
    .btn_db_o(btn_db)
  );
  assign press = btn_db & ~db_q;
  assign eq = bus.R_P == bus.G_P;
  // one equal sample is a lamp changeover; two in a row is a real fault
  assign fault_d = fault_q | (eq & eq_q);
  assign bus.sw = sw_q;
  assign bus.wait_lamp = wait_q;
  assign bus.fault = fault_q;
`ifdef SEMAFOR_PED_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_HALF + 1);
  logic [BW-1:0] blink_q, blink_d;
  assign blink_d = (blink_q == BW'(2 * BLINK_HALF - 1)) ? '0 : blink_q + 1'b1;
  assign blink_on = blink_d < BW'(BLINK_HALF);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blink_q <= '0;
    else blink_q <= (state_q == REQ && !bus.G_P && !fault_d) ? blink_d : '0;
`else
  logic unused_blink;
  assign blink_on = 1'b1;
  assign unused_blink = |BLINK_HALF;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      db_q <= 1'b0;
      eq_q <= 1'b0;
      fault_q <= 1'b0;
      pending_q <= 1'b0;
      sw_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      db_q <= btn_db;
      eq_q <= eq;
      fault_q <= fault_d;
      sw_q <= 1'b0;
      wait_q <= 1'b0;
      if (fault_d) begin
        state_q <= IDLE;
        cnt_q <= '0;
        pending_q <= 1'b0;
      end else
        case (state_q)
          IDLE: if (press && !bus.G_P) begin
            state_q <= REQ;
            sw_q <= 1'b1;
            wait_q <= 1'b1;
          end
          REQ: if (bus.G_P) state_q <= WALK;
          else begin
            sw_q <= 1'b1;
            wait_q <= blink_on;
          end
          WALK: if (!bus.G_P) begin
            state_q <= COOL;
            cnt_q <= CW'(COOLDOWN_CYCLES);
          end
          COOL: if (cnt_q == CW'(1)) begin
            state_q <= (pending_q | press) ? REQ : IDLE;
            sw_q <= pending_q | press;
            wait_q <= pending_q | press;
            pending_q <= 1'b0;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            pending_q <= pending_q | press;
          end
        endcase
    end
endmodule
